nios_blink_pio_blink: RTL and testbench
=======================================

NIOS_BLINK_PIO_BLINK -- requirements
Module: nios_blink_pio_blink

Interface
REQ-001 SHALL take parameter WIDTH, default 4: out_port width; legal range 1..32.
REQ-002 SHALL take parameter RESET_VALUE, default 0: data register value after reset.
REQ-003 SHALL take parameter PRESCALE_W, default 24: width of period register and prescale counter; legal range 1..32.
REQ-004 SHALL take parameter RESET_PERIOD, default 0: period register value after reset.
REQ-005 SHALL provide clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL provide reset_n  input  1  reset: asynchronous, active-low.
REQ-007 SHALL provide address  input  3  Avalon-MM word offset.
REQ-008 SHALL provide chipselect  input  1  slave select.
REQ-009 SHALL provide write_n  input  1  active-low write strobe.
REQ-010 SHALL provide writedata  input  32  write data.
REQ-011 SHALL provide readdata  output  32  read data, zero-extended.
REQ-012 SHALL provide out_port  output  WIDTH  LED drive.
REQ-013 SHALL provide tick  output  1  one-cycle pulse on each blink phase toggle.

Function
REQ-014 SHALL accept a write only when chipselect=1 and write_n=0, capturing it on that clk edge.
REQ-015 SHALL map offset 0 as DATA (RW, writedata[WIDTH-1:0]), 1 as MASK (RW, blink-enable per bit), 2 as PERIOD (RW, writedata[PRESCALE_W-1:0]), and 3 as STATUS (RO: bit0 = phase; writes ignored).
REQ-016 SHALL drive readdata combinationally from address, independent of chipselect (read latency 0), with unused upper bits 0 and offsets 6..7 reading 0.
REQ-017 SHALL drive out_port[i] = DATA[i] when MASK[i]=0, else DATA[i] & phase.
REQ-018 SHALL, when PERIOD=P>0, increment counter cnt each cycle; when cnt==P: cnt<=0, phase<=~phase, tick=1 that same cycle; half-period = P+1 cycles.
REQ-019 SHALL, when PERIOD=0, hold cnt=0, hold phase=1, and keep tick=0.
REQ-020 SHALL, on any write to PERIOD, load cnt<=0 and phase<=1 on that edge; the terminal compare that cycle is overridden (no tick, no toggle).
REQ-021 SHALL apply DATA/MASK writes to out_port on the cycle after the write edge, without disturbing cnt or phase.
REQ-022 SHALL ignore writes to offset 3 and offsets 6..7 without side effects.
REQ-023 SHALL make counter wrap at P = 2^PRESCALE_W-1 behave identically to any other P; cnt never exceeds P.

Reset
REQ-024 SHALL, while reset_n=0 (including mid-phase), force DATA=RESET_VALUE, MASK=0, PERIOD=RESET_PERIOD, cnt=0, phase=1; tick=0 and out_port=RESET_VALUE.
REQ-025 SHALL restart counting from cnt=0 on the first clk edge after reset_n deasserts.

Configuration
REQ-026 SHALL, with macro NIOS_BLINK_PIO_BITSET_EN defined, map offset 4 as OUTSET (DATA <= DATA | writedata[WIDTH-1:0]) and offset 5 as OUTCLEAR (DATA <= DATA & ~writedata[WIDTH-1:0]), both reading 0.
REQ-027 SHALL, without NIOS_BLINK_PIO_BITSET_EN, ignore writes to offsets 4..5 and read them as 0, with no set/clear logic synthesised.

Verification
REQ-028 SHALL cover: reset with RESET_VALUE=4'hA -> out_port=4'hA, readdata@0=0x0000000A, @1=0, @3=0x1.
REQ-029 SHALL cover: DATA=0xF, MASK=0x3, PERIOD=3 -> tick every 4 cycles; out_port alternates 0xF / 0xC every 4 cycles; STATUS bit0 toggles in step.
REQ-030 SHALL cover: PERIOD rewritten to 5 while cnt=2 -> cnt=0 and phase=1 next cycle, no tick that cycle, first tick 6 cycles later.
REQ-031 SHALL cover: PERIOD=0 with MASK=0xF, DATA=0x5 -> out_port steady 0x5, tick never asserts over 100 cycles.
REQ-032 SHALL cover: with BITSET_EN, DATA=0x1, write 0x4 @4 then 0x1 @5 -> DATA=0x5 then 0x4; without the macro -> DATA stays 0x1.
REQ-033 SHALL cover: reset_n asserted mid-blink (phase=0, cnt=2) -> out_port=RESET_VALUE immediately (asynchronously), MASK=0, PERIOD=RESET_PERIOD.

Source files
------------

// File: rtl/nios_blink_pio_blink_if.sv
// Avalon-MM slave bus for the blink PIO: 3-bit word offset, 32-bit data, zero-latency reads.
interface nios_blink_pio_blink_if;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_blink_pio_blink.sv
// Avalon-MM LED PIO with per-bit blink mask, programmable half-period prescaler and toggle tick.
// Define NIOS_BLINK_PIO_BITSET_EN to add OUTSET (offset 4) / OUTCLEAR (offset 5) write ports.
module nios_blink_pio_blink #(
    parameter int unsigned                WIDTH        = 4,
    parameter logic [WIDTH-1:0]           RESET_VALUE  = '0,
    parameter int unsigned                PRESCALE_W   = 24,
    parameter logic [PRESCALE_W-1:0]      RESET_PERIOD = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    nios_blink_pio_blink_if.slave        bus,
    output logic [WIDTH-1:0]             out_port,
    output logic                         tick
);

    localparam int unsigned DATA_W      = 32;
    localparam logic [2:0]  ADDR_DATA   = 3'd0;
    localparam logic [2:0]  ADDR_MASK   = 3'd1;
    localparam logic [2:0]  ADDR_PERIOD = 3'd2;
    localparam logic [2:0]  ADDR_STATUS = 3'd3;
`ifdef NIOS_BLINK_PIO_BITSET_EN
    localparam logic [2:0]  ADDR_OUTSET = 3'd4;
    localparam logic [2:0]  ADDR_OUTCLR = 3'd5;
`endif

    logic [WIDTH-1:0]      data_q,     data_d;
    logic [WIDTH-1:0]      mask_q,     mask_d;
    logic [PRESCALE_W-1:0] period_q,   period_d;
    logic [PRESCALE_W-1:0] cnt_q,      cnt_d;
    logic                  phase_q,    phase_d;
    logic                  tick_q,     tick_d;
    logic [WIDTH-1:0]      out_port_q, out_port_d;
    logic                  wr_en_c;
    logic [DATA_W-1:0]     readdata_c;
    logic                  unused_wdata_c;

    assign wr_en_c        = bus.chipselect && !bus.write_n;
    assign unused_wdata_c = ^bus.writedata;

    // Register writes and the prescaler; a PERIOD write restarts the blink phase.
    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;

        if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == period_q) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + PRESCALE_W'(1);
        end

        if (wr_en_c) begin
            case (bus.address)
                ADDR_DATA:   data_d = bus.writedata[WIDTH-1:0];
                ADDR_MASK:   mask_d = bus.writedata[WIDTH-1:0];
                ADDR_PERIOD: begin
                    period_d = bus.writedata[PRESCALE_W-1:0];
                    cnt_d    = '0;
                    phase_d  = 1'b1;
                end
`ifdef NIOS_BLINK_PIO_BITSET_EN
                ADDR_OUTSET: data_d = data_q | bus.writedata[WIDTH-1:0];
                ADDR_OUTCLR: data_d = data_q & ~bus.writedata[WIDTH-1:0];
`endif
                default: ;
            endcase
        end

        // Outputs are precomputed from next state so the flops mirror the current cnt/phase.
        tick_d     = (period_d != '0) && (cnt_d == period_d);
        out_port_d = data_d & (~mask_d | {WIDTH{phase_d}});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            mask_q     <= '0;
            period_q   <= RESET_PERIOD;
            cnt_q      <= '0;
            phase_q    <= 1'b1;
            tick_q     <= 1'b0;
            out_port_q <= RESET_VALUE;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            tick_q     <= tick_d;
            out_port_q <= out_port_d;
        end
    end

    // Zero-latency read mux, independent of chipselect.
    always_comb begin
        readdata_c = '0;
        case (bus.address)
            ADDR_DATA:   readdata_c = DATA_W'(data_q);
            ADDR_MASK:   readdata_c = DATA_W'(mask_q);
            ADDR_PERIOD: readdata_c = DATA_W'(period_q);
            ADDR_STATUS: readdata_c = DATA_W'(phase_q);
            default:     readdata_c = '0;
        endcase
    end

    assign bus.readdata = readdata_c;
    assign out_port     = out_port_q;
    assign tick         = tick_q;

endmodule

// File: tb/tb_nios_blink_pio_blink.sv
// Scoreboard bench for nios_blink_pio_blink: directed scenarios then random bus traffic vs. a phase-arithmetic model.
module tb_nios_blink_pio_blink;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned PW    = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] out_port;
    logic             tick;

    nios_blink_pio_blink_if bus();

    nios_blink_pio_blink #(
        .WIDTH        (WIDTH),
        .RESET_VALUE  (4'hA),
        .PRESCALE_W   (PW),
        .RESET_PERIOD (4'h0)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  out;
        logic        tck;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Model: k counts edges since the last PERIOD load / reset; phase and tick follow by division.
    logic [3:0]  m_data, m_mask, m_period;
    int          m_k;
    logic        c_rst, c_cs, c_wn;
    logic [2:0]  c_addr;
    logic [31:0] c_wd;

    function automatic void model_reset();
        m_data   = 4'hA;
        m_mask   = 4'h0;
        m_period = 4'h0;
        m_k      = 0;
    endfunction

    function automatic void model_edge();
        if (!c_rst) return;
        m_k = m_k + 1;
        if (c_cs && !c_wn) begin
            case (c_addr)
                3'd0: m_data = c_wd[3:0];
                3'd1: m_mask = c_wd[3:0];
                3'd2: begin m_period = c_wd[3:0]; m_k = 0; end
`ifdef NIOS_BLINK_PIO_BITSET_EN
                3'd4: m_data = m_data | c_wd[3:0];
                3'd5: m_data = m_data & ~c_wd[3:0];
`endif
                default: ;
            endcase
        end
    endfunction

    function automatic logic m_phase();
        if (m_period == 4'h0) return 1'b1;
        return ((m_k / (int'(m_period) + 1)) % 2) == 0;
    endfunction

    function automatic logic m_tick();
        if (m_period == 4'h0) return 1'b0;
        return (m_k % (int'(m_period) + 1)) == int'(m_period);
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        e.out = m_data & (~m_mask | (m_phase() ? 4'hF : 4'h0));
        e.tck = m_tick();
        case (c_addr)
            3'd0:    e.rd = {28'h0, m_data};
            3'd1:    e.rd = {28'h0, m_mask};
            3'd2:    e.rd = {28'h0, m_period};
            3'd3:    e.rd = {31'h0, m_phase()};
            default: e.rd = 32'h0;
        endcase
        return e;
    endfunction

    // One bus cycle: retire the previous inputs at the edge, then present new ones.
    task automatic cyc(input logic r, input logic cs, input logic wn,
                       input logic [2:0] a, input logic [31:0] wd);
        @(posedge clk);
        model_edge();
        #2;
        reset_n       = r;
        bus.chipselect = cs;
        bus.write_n   = wn;
        bus.address   = a;
        bus.writedata = wd;
        c_rst = r; c_cs = cs; c_wn = wn; c_addr = a; c_wd = wd;
        if (!r) model_reset();
        exp_q.push_back(model_expect());
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        cyc(1'b1, 1'b1, 1'b0, a, wd);
    endtask

    task automatic idle(input int n, input logic [2:0] a);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, a, $urandom);
    endtask

    // Monitor: every cycle the DUT presents out_port/tick/readdata; compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (out_port !== e.out || tick !== e.tck || bus.readdata !== e.rd) begin
                    miscompares++;
                    $display("FAIL vec%0d addr=%0d: out_port=%h tick=%b readdata=%h, required out_port=%h tick=%b readdata=%h",
                             vectors, bus.address, out_port, tick, bus.readdata, e.out, e.tck, e.rd);
                end
            end
        end
    end

    initial begin
        logic [2:0]  a;
        logic [31:0] wd;
        reset_n = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'h0;
        c_rst = 1'b0; c_cs = 1'b0; c_wn = 1'b1; c_addr = 3'd0; c_wd = 32'h0;
        model_reset();

        // Reset values on DATA, MASK, STATUS.
        cyc(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 3'd1, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 3'd3, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);

        // Blink with period 3: 4-cycle half-periods.
        wr(3'd0, 32'hF); wr(3'd1, 32'h3); wr(3'd2, 32'h3);
        idle(12, 3'd3);

        // PERIOD rewritten to 5 while cnt=2.
        wr(3'd2, 32'h3);
        idle(2, 3'd3);
        wr(3'd2, 32'h5);
        idle(14, 3'd3);

        // PERIOD=0: steady output, no tick.
        wr(3'd1, 32'hF); wr(3'd0, 32'h5); wr(3'd2, 32'h0);
        for (int i = 0; i < 100; i++) idle(1, 3'($urandom_range(0, 7)));

        // Set/clear ports (ignored without the macro).
        wr(3'd0, 32'h1); wr(3'd4, 32'h4); idle(1, 3'd0);
        wr(3'd5, 32'h1); idle(1, 3'd0);

        // Reset mid-blink (phase=0, cnt=2), then restart.
        wr(3'd1, 32'h3); wr(3'd0, 32'hF); wr(3'd2, 32'h3);
        idle(6, 3'd3);
        cyc(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 3'd1, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 3'd2, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 3'd3, 32'h0);
        wr(3'd2, 32'hF); idle(40, 3'd3);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd2)
                wd = (wd & 32'hFFFF_FFF0) |
                     (($urandom_range(0, 9) == 0) ? 32'hF : 32'($urandom_range(0, 6)));
            cyc(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) != 0), a, wd);
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
